// File: rtl/seg7_mux_capture.sv
// Receive side of a two-digit multiplexed 7-segment bus: synchronise, debounce,
// decode each lit digit back to a nibble and reassemble {high, low} byte pairs.
module seg7_mux_capture #(
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 1048576
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic [6:0] i_segs,
  input  logic       i_digit_sel,
  output logic [7:0] o_value,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_active
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [7:0]    sync1, sync2, samp_prev;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          changed, accept, lit, hit;
  logic [3:0]    nib;
  logic [3:0]    hi_nib, lo_nib;
  logic          hi_pend, lo_pend;

  assign changed = (sync2 != samp_prev);
  // Fires on the single cycle the run length reaches STABLE_CYCLES.
  assign accept  = changed ? (STABLE_CYCLES == 1) : (cnt == CW'(STABLE_CYCLES - 1));
  assign lit     = (sync2[6:0] != 7'd0);

  always_comb begin
    hit = 1'b1;
    nib = 4'h0;
    case (sync2[6:0])
      7'b1111110: nib = 4'h0;
      7'b0110000: nib = 4'h1;
      7'b1101101: nib = 4'h2;
      7'b1111001: nib = 4'h3;
      7'b0110011: nib = 4'h4;
      7'b1011011: nib = 4'h5;
      7'b1011111: nib = 4'h6;
      7'b1110000: nib = 4'h7;
      7'b1111111: nib = 4'h8;
      7'b1111011: nib = 4'h9;
      7'b1110111: nib = 4'hA;
      7'b0011111: nib = 4'hB;
      7'b1001110: nib = 4'hC;
      7'b0111101: nib = 4'hD;
      7'b1001111: nib = 4'hE;
      7'b1000111: nib = 4'hF;
      default:    hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      samp_prev <= '0;
      cnt       <= '0;
    end else begin
      sync1     <= {i_digit_sel, i_segs};
      sync2     <= sync1;
      samp_prev <= sync2;
      if (changed)
        cnt <= CW'(1);
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      o_value  <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      o_active <= 1'b0;
      timer    <= '0;
      hi_nib   <= '0;
      lo_nib   <= '0;
      hi_pend  <= 1'b0;
      lo_pend  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (accept && lit) begin
        // A lit accept outranks a timeout expiring on the same edge.
        timer    <= TW'(TIMEOUT);
        o_active <= 1'b1;
        if (!hit) begin
          o_err <= 1'b1;
        end else if (sync2[7]) begin
          hi_nib <= nib;
          if (lo_pend) begin
            o_value <= {nib, lo_nib};
            o_valid <= 1'b1;
            hi_pend <= 1'b0;
            lo_pend <= 1'b0;
          end else begin
            hi_pend <= 1'b1;
          end
        end else begin
          lo_nib <= nib;
          if (hi_pend) begin
            o_value <= {hi_nib, nib};
            o_valid <= 1'b1;
            hi_pend <= 1'b0;
            lo_pend <= 1'b0;
          end else begin
            lo_pend <= 1'b1;
          end
        end
      end else if (timer != '0) begin
        timer <= timer - TW'(1);
        if (timer == TW'(1)) begin
          o_active <= 1'b0;
          hi_pend  <= 1'b0;
          lo_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_mux_capture.sv
// Bench for seg7_mux_capture: cycle-by-cycle comparison against an event-level
// reference model, a digit table, directed corner sequences and random traffic.
module tb_seg7_mux_capture;
  localparam int STABLE = 2;
  localparam int TMO    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] segs = '0;
  logic       sel = 1'b0;
  logic [7:0] value;
  logic       valid, err, active;

  seg7_mux_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
    .clk_25mhz(clk), .rst_n(rst_n), .i_segs(segs), .i_digit_sel(sel),
    .o_value(value), .o_valid(valid), .o_err(err), .o_active(active)
  );

  always #20 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111 };

  typedef struct { int t; logic [7:0] v; } ev_t;
  ev_t evq[$];

  typedef struct { logic [6:0] hi; logic [6:0] lo; logic [7:0] val; int nv; int ne; } vec_t;
  vec_t vecs [9];

  int n_cmp = 0, n_bad = 0;
  int cyc, run_len, tl;
  int n_valid = 0, n_err = 0, first_valid = -1, lo_start = 0;
  logic [7:0] last_in, exp_value;
  logic       exp_valid, exp_err;
  bit         hp, lp;
  logic [3:0] hn, ln;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit lookup(input logic [6:0] p, output logic [3:0] n);
    n = 4'h0;
    lookup = 1'b0;
    for (int i = 0; i < 16; i++)
      if (seg_tab[i] == p) begin n = 4'(i); lookup = 1'b1; end
  endfunction

  task automatic model_reset();
    cyc = 0; evq.delete(); last_in = 8'h00; run_len = STABLE;
    exp_value = 8'h00; hp = 0; lp = 0; hn = 0; ln = 0; tl = -100000;
  endtask

  // Applies one accepted sample to the expected pair/timer state.
  task automatic apply(input logic [7:0] v);
    logic [3:0] n;
    if (v[6:0] == 7'd0) return;
    if (cyc - tl > TMO) begin hp = 0; lp = 0; end
    tl = cyc;
    if (!lookup(v[6:0], n)) exp_err = 1'b1;
    else if (v[7]) begin
      hn = n;
      if (lp) begin exp_value = {n, ln}; exp_valid = 1'b1; lp = 0; end else hp = 1;
    end else begin
      ln = n;
      if (hp) begin exp_value = {hn, n}; exp_valid = 1'b1; hp = 0; end else lp = 1;
    end
  endtask

  task automatic step(input logic s, input logic [6:0] p);
    sel = s; segs = p;
    @(posedge clk);
    cyc++;
    if ({s, p} != last_in) begin last_in = {s, p}; run_len = 0; end
    if (run_len < STABLE) begin
      run_len++;
      if (run_len == STABLE) evq.push_back('{cyc + 2, last_in});
    end
    exp_valid = 1'b0; exp_err = 1'b0;
    while (evq.size() > 0 && evq[0].t == cyc) apply(evq.pop_front().v);
    #1;
    check("value", value, exp_value);
    check("valid", valid, exp_valid);
    check("err", err, exp_err);
    check("active", active, 32'((cyc - tl) < TMO));
    if (valid) begin n_valid++; if (first_valid < 0) first_valid = cyc; end
    if (err) n_err++;
  endtask

  task automatic hold(input logic s, input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) step(s, p);
  endtask

  task automatic mux_loop(input logic [6:0] hi, input logic [6:0] lo, input int ph);
    hold(1, hi, 2 * ph); hold(1, 0, ph); hold(0, 0, ph);
    lo_start = cyc;
    hold(0, lo, 2 * ph); hold(0, 0, ph); hold(1, 0, ph);
  endtask

  task automatic reset_phase(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      segs = 7'($urandom); sel = 1'($urandom);
      @(posedge clk); #1;
      check("rst_value", value, 0); check("rst_valid", valid, 0);
      check("rst_err", err, 0);     check("rst_active", active, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, acc;
    vecs[0] = '{7'b1111001, 7'b1110111, 8'h3A, 1, 0};
    vecs[1] = '{7'b1111110, 7'b0110000, 8'h01, 1, 0};
    vecs[2] = '{7'b1101101, 7'b0110011, 8'h24, 1, 0};
    vecs[3] = '{7'b1011011, 7'b1011111, 8'h56, 1, 0};
    vecs[4] = '{7'b1110000, 7'b1111111, 8'h78, 1, 0};
    vecs[5] = '{7'b1111011, 7'b0011111, 8'h9B, 1, 0};
    vecs[6] = '{7'b1001110, 7'b0111101, 8'hCD, 1, 0};
    vecs[7] = '{7'b1001111, 7'b1000111, 8'hEF, 1, 0};
    vecs[8] = '{7'b1010101, 7'b0000001, 8'hEF, 0, 2};
    model_reset();

    // Reset state and idle blank bus
    reset_phase(8);
    hold(0, 0, 100);
    check("idle_valids", n_valid, 0);
    check("idle_active", active, 0);

    // Reference multiplex loop and first-strobe latency
    first_valid = -1; v0 = n_valid;
    mux_loop(7'b1111001, 7'b1110111, 2);
    check("latency", first_valid, lo_start + 4);
    for (int i = 0; i < 4; i++) mux_loop(7'b1111001, 7'b1110111, 2);
    check("loop_valids", n_valid - v0, 5);
    check("loop_value", value, 8'h3A);

    // Counter sweep
    e0 = n_err;
    for (int i = 0; i < 256; i++) begin
      mux_loop(seg_tab[i / 16], seg_tab[i % 16], 2);
      check("sweep_value", value, 32'(i));
    end
    check("sweep_errs", n_err - e0, 0);

    // Decode table vectors
    foreach (vecs[i]) begin
      v0 = n_valid; e0 = n_err;
      mux_loop(vecs[i].hi, vecs[i].lo, 2);
      check("vec_value", value, vecs[i].val);
      check("vec_valids", n_valid - v0, vecs[i].nv);
      check("vec_errs", n_err - e0, vecs[i].ne);
    end

    // Single-cycle glitch, then a stable invalid pattern
    v0 = n_valid; e0 = n_err;
    hold(1, 0, 4); step(1, 7'b1111111); hold(1, 0, 6);
    check("glitch_valids", n_valid - v0, 0);
    check("glitch_errs", n_err - e0, 0);
    hold(0, 7'b1010101, 4); hold(0, 0, 4);
    check("invalid_errs", n_err - e0, 1);
    check("invalid_value", value, 8'hEF);

    // Ordering: low first, then high; high overwritten before low
    hold(0, 7'b1011011, 3); hold(0, 0, 3); hold(1, 7'b1001110, 3); hold(1, 0, 4);
    check("order_c5", value, 8'hC5);
    v0 = n_valid;
    hold(1, 7'b0110000, 3); hold(1, 0, 3); hold(1, 7'b1101101, 3); hold(1, 0, 3);
    hold(0, 7'b1110000, 3); hold(0, 0, 4);
    check("order_27", value, 8'h27);
    check("order_valids", n_valid - v0, 1);

    // Timeout: pending high digit dropped once activity lapses
    hold(0, 0, 20);
    acc = cyc + 4;
    hold(1, 7'b0110011, 3);
    for (int i = 0; i < 25; i++) begin
      step(1, 0);
      if (cyc == acc + TMO - 1) check("tmo_still_active", active, 1);
      if (cyc == acc + TMO)     check("tmo_fallen", active, 0);
    end
    v0 = n_valid;
    hold(0, 7'b0110000, 3); hold(0, 0, 4);
    check("tmo_pend_clear", n_valid - v0, 0);
    hold(0, 0, 20);

    // Reset in the middle of a pair
    hold(1, 7'b1111110, 3); hold(1, 0, 3);
    reset_phase(5);
    v0 = n_valid;
    hold(0, 7'b1011011, 3); hold(0, 0, 6);
    check("rst_mid_pair", n_valid - v0, 0);
    check("rst_mid_value", value, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int kind;
      logic [6:0] p;
      kind = $urandom_range(0, 11);
      if (kind < 2)       p = 7'd0;
      else if (kind == 2) p = 7'($urandom);
      else                p = seg_tab[$urandom_range(0, 15)];
      if (kind == 11) hold(1'($urandom), 7'd0, 20);
      else hold(1'($urandom), p, $urandom_range(1, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
